serializer: RTL

- Transmit end of the 3-bit-address / 16-bit-data serial link; serializes one {P_ADDR, P_DATA} word into a 19-bit frame.
- Drives a free-running serial clock TX_SCLK, serial data TX_DATA and the frame strobe TX_LOAD to the remote deserializer.
- Frame is MSB first; TX_LOAD is asserted together with the last bit, so the receiver latches the word on the same TX_SCLK rising edge that captures bit 0.
- Sits between the local register/command logic and the board-to-board connector.

---
 rtl/serializer_pkg.sv | 34 +++
 rtl/serializer_fifo.sv | 61 ++++++
 rtl/serializer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// -----------------------------------------------------------------------------
// serializer_pkg
//   Shared definitions for the 3-bit-address / 16-bit-data serial link.
//   The remote deserializer uses the same widths.
//   Contents:
//     ADDR_W, DATA_W, FRAME_W : word and frame widths
//     CNT_W                   : width of the completed-frame counter
//     BITCNT_W                : width of the in-frame bit counter
//     ser_state_e             : transmit state machine states
//     frame_t / pack_frame    : 19-bit frame type and {addr, data} packing
// -----------------------------------------------------------------------------
package serializer_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FRAME_W  = ADDR_W + DATA_W;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned BITCNT_W = $clog2(FRAME_W);

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WAIT,
        SHIFT,
        GAP
    } ser_state_e;

    typedef logic [FRAME_W-1:0] frame_t;

    function automatic frame_t pack_frame(input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/serializer_fifo.sv
// -----------------------------------------------------------------------------
// serializer_fifo
//   Synchronous FIFO holding frames waiting for the shifter.
//   Parameters: WIDTH (entry width), DEPTH (entries, power of two, >= 2).
//   Ports:
//     clk_i    : clock, rising edge
//     rst_ni   : asynchronous active-low reset (empties the FIFO)
//     push_i   : write data_i (ignored when full)
//     data_i   : entry to write
//     pop_i    : drop the head entry (ignored when empty)
//     data_o   : head entry (valid while !empty_o)
//     full_o   : no free entry
//     empty_o  : no stored entry
// -----------------------------------------------------------------------------
module serializer_fifo
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = FRAME_W,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//   Transmit end of the 3-bit-address / 16-bit-data serial link. Sends each
//   accepted {P_ADDR, P_DATA} word MSB first as a 19-bit frame on TX_DATA,
//   clocked by the free-running TX_SCLK; TX_LOAD marks the last bit.
//   Optional build macro: SERIALIZER_FIFO_EN (FIFO_DEPTH-entry input FIFO,
//   frames go out back-to-back separated only by the gap).
//   Parameters: CLK_DIV (TX_SCLK half period in CLK cycles), GAP_BITS (idle
//   TX_SCLK periods after each frame), FIFO_DEPTH (FIFO build only).
//   Ports:
//     CLK     : system clock, rising edge
//     RST     : asynchronous active-low reset
//     P_ADDR  : word address, frame bits [18:16]
//     P_DATA  : word data, frame bits [15:0]
//     P_VALID : word offered
//     P_READY : word accepted when P_VALID && P_READY
//     TX_SCLK : serial clock, remote samples on rising edge
//     TX_DATA : serial data, changes on TX_SCLK falling events
//     TX_LOAD : high during the last bit period of a frame
//     TX_BUSY : high from acceptance through the end of the gap
//     TX_CNT  : completed frames, wrapping
// -----------------------------------------------------------------------------
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_BITS   = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] P_ADDR,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              P_VALID,
    output logic              P_READY,
    output logic              TX_SCLK,
    output logic              TX_DATA,
    output logic              TX_LOAD,
    output logic              TX_BUSY,
    output logic [CNT_W-1:0]  TX_CNT
);

    if (CLK_DIV < 1 || GAP_BITS < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("serializer: illegal CLK_DIV / GAP_BITS / FIFO_DEPTH");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(GAP_BITS - 1);
    localparam logic [BITCNT_W-1:0] BIT_TOP  = BITCNT_W'(FRAME_W - 1);

    // ---------------------------------------------------------------- divider
    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             div_wrap;
    logic             fall_evt;

    assign div_wrap = (div_q == DIV_LAST);
    // The only cycle in which serial outputs and the FSM may move.
    assign fall_evt = div_wrap && sclk_q;

    always_comb begin
        div_d  = div_q + DIV_W'(1);
        sclk_d = sclk_q;
        if (div_wrap) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    // ------------------------------------------------------------ FSM state
    ser_state_e          state_q;
    frame_t              shreg_q;
    logic [BITCNT_W-1:0] bitcnt_q;
    logic [GAP_W-1:0]    gapcnt_q;
    logic                data_q;
    logic                load_q;
    logic                busy_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                gap_done;
    logic                start;
    frame_t              start_word;

    assign gap_done = fall_evt && (state_q == GAP) && (gapcnt_q == GAP_LAST);

`ifdef SERIALIZER_FIFO_EN
    logic   fifo_full;
    logic   fifo_empty;
    logic   fifo_pop;
    frame_t fifo_head;
    logic   restart;

    // A waiting frame follows the gap directly, skipping IDLE and LOAD_WAIT,
    // so consecutive frames are separated by exactly GAP_BITS periods.
    assign restart    = gap_done && !fifo_empty;
    assign start      = (state_q == IDLE) && !fifo_empty;
    assign start_word = fifo_head;
    assign fifo_pop   = start || restart;
    assign P_READY    = RST && !fifo_full;

    serializer_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (P_VALID && P_READY),
        .data_i  (pack_frame(P_ADDR, P_DATA)),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
`else
    assign P_READY    = RST && (state_q == IDLE);
    assign start      = P_VALID && P_READY;
    assign start_word = pack_frame(P_ADDR, P_DATA);
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            data_q   <= 1'b0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q <= start_word;
                        busy_q  <= 1'b1;
                        state_q <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (fall_evt) begin
                        data_q   <= shreg_q[FRAME_W-1];
                        shreg_q  <= shreg_q << 1;
                        bitcnt_q <= BIT_TOP;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (fall_evt) begin
                        if (bitcnt_q == '0) begin
                            data_q   <= 1'b0;
                            load_q   <= 1'b0;
                            cnt_q    <= cnt_q + CNT_W'(1);
                            gapcnt_q <= '0;
                            state_q  <= GAP;
                        end else begin
                            data_q   <= shreg_q[FRAME_W-1];
                            shreg_q  <= shreg_q << 1;
                            bitcnt_q <= bitcnt_q - BITCNT_W'(1);
                            // Counter about to reach 0: bit 0 goes out now.
                            load_q   <= (bitcnt_q == BITCNT_W'(1));
                        end
                    end
                end
                GAP: begin
                    if (fall_evt) begin
                        if (gapcnt_q == GAP_LAST) begin
`ifdef SERIALIZER_FIFO_EN
                            if (!fifo_empty) begin
                                data_q   <= fifo_head[FRAME_W-1];
                                shreg_q  <= fifo_head << 1;
                                bitcnt_q <= BIT_TOP;
                                state_q  <= SHIFT;
                            end else begin
                                busy_q  <= 1'b0;
                                state_q <= IDLE;
                            end
`else
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
`endif
                        end else begin
                            gapcnt_q <= gapcnt_q + GAP_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign TX_SCLK = sclk_q;
    assign TX_DATA = data_q;
    assign TX_LOAD = load_q;
    assign TX_BUSY = busy_q;
    assign TX_CNT  = cnt_q;

endmodule
